// File: rtl/bopit_engine.sv
// bopit_engine: reaction-game controller. Issues a random switch/button command,
// times the response in ticks, and tracks BCD score, lives and difficulty level.
//   state | meaning
//   IDLE  | waiting for start after reset
//   ARM   | one cycle: pick command, load response window
//   WAIT  | watching for the commanded action or a timeout
//   WIN   | counting DELAY ticks before scoring and re-arming
//   OVER  | lives exhausted, outputs frozen until start
module bopit_engine #(
    parameter int N_SW    = 8,
    parameter int N_BTN   = 4,
    parameter int LIVES   = 3,
    parameter int T_START = 10,
    parameter int T_MIN   = 3,
    parameter int STEP    = 5,
    parameter int DELAY   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic [N_SW-1:0]  sw,
    input  logic [N_BTN-1:0] btn,
    input  logic [7:0]       rnd,
    output logic [4:0]       cmd,
    output logic             cmd_is_btn,
    output logic [6:0]       time_left,
    output logic [3:0]       score_tens,
    output logic [3:0]       score_ones,
    output logic [2:0]       lives_left,
    output logic [2:0]       state,
    output logic             snd_ok,
    output logic             snd_fail,
    output logic             game_over
);
    localparam int NA = N_SW + N_BTN;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_WAIT = 3'd2,
        S_WIN  = 3'd3,
        S_OVER = 3'd4
    } state_t;

    state_t           r_state;
    logic [N_SW-1:0]  r_sw_q;
    logic [N_BTN-1:0] r_btn_q;
    logic [4:0]       r_cmd;
    logic [6:0]       r_time;
    logic [3:0]       r_tens;
    logic [3:0]       r_ones;
    logic [2:0]       r_lives;
    logic [6:0]       r_level;
    logic [3:0]       r_wins;
    logic [7:0]       r_dly;
    logic             r_snd_ok;
    logic             r_snd_fail;
    logic             r_game_over;

    logic [NA-1:0]    w_act;
    logic [NA-1:0]    w_cmd_oh;
    logic             w_any;
    logic             w_hit;
    logic             w_miss;
    logic [6:0]       w_t_raw;
    logic [6:0]       w_arm_time;
    logic [2:0]       w_lives_dec;

    // Action vector uses the same indexing as command codes: switches low, buttons high.
    assign w_act       = {btn & ~r_btn_q, sw ^ r_sw_q};
    assign w_cmd_oh    = NA'(1) << r_cmd;
    assign w_any       = |w_act;
    assign w_hit       = (w_act == w_cmd_oh);
    assign w_miss      = (r_state == S_WAIT) && (w_any ? !w_hit : (tick && r_time == 7'd1));
    assign w_t_raw     = 7'(T_START) - r_level;
    assign w_arm_time  = (w_t_raw > 7'(T_MIN)) ? w_t_raw : 7'(T_MIN);
    assign w_lives_dec = r_lives - 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sw_q      <= sw;
            r_btn_q     <= btn;
            r_cmd       <= '0;
            r_time      <= '0;
            r_tens      <= '0;
            r_ones      <= '0;
            r_lives     <= 3'(LIVES);
            r_level     <= '0;
            r_wins      <= '0;
            r_dly       <= '0;
            r_snd_ok    <= 1'b0;
            r_snd_fail  <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_sw_q     <= sw;
            r_btn_q    <= btn;
            r_snd_ok   <= 1'b0;
            r_snd_fail <= 1'b0;
            if (start) begin
                r_state     <= S_ARM;
                r_tens      <= '0;
                r_ones      <= '0;
                r_lives     <= 3'(LIVES);
                r_level     <= '0;
                r_wins      <= '0;
                r_game_over <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: ;
                    S_ARM: begin
                        r_cmd   <= 5'(rnd % 8'(NA));
                        r_time  <= w_arm_time;
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (w_miss) begin
                            r_snd_fail <= 1'b1;
                            r_lives    <= w_lives_dec;
                            if (w_lives_dec == 3'd0) begin
                                r_state     <= S_OVER;
                                r_game_over <= 1'b1;
                            end else begin
                                r_state <= S_ARM;
                            end
                        end else if (w_any) begin
                            r_snd_ok <= 1'b1;
                            r_dly    <= 8'(DELAY);
                            r_state  <= S_WIN;
                        end else if (tick) begin
                            r_time <= r_time - 7'd1;
                        end
                    end
                    S_WIN: begin
                        if (tick) begin
                            if (r_dly <= 8'd1) begin
                                // BCD increment, holding at 99
                                if (!(r_tens == 4'd9 && r_ones == 4'd9)) begin
                                    if (r_ones == 4'd9) begin
                                        r_ones <= 4'd0;
                                        r_tens <= r_tens + 4'd1;
                                    end else begin
                                        r_ones <= r_ones + 4'd1;
                                    end
                                end
                                if (r_wins == 4'(STEP - 1)) begin
                                    r_wins <= '0;
                                    if (w_t_raw > 7'(T_MIN))
                                        r_level <= r_level + 7'd1;
                                end else begin
                                    r_wins <= r_wins + 4'd1;
                                end
                                r_state <= S_ARM;
                            end else begin
                                r_dly <= r_dly - 8'd1;
                            end
                        end
                    end
                    S_OVER: ;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign cmd        = r_cmd;
    assign cmd_is_btn = (r_cmd >= 5'(N_SW));
    assign time_left  = r_time;
    assign score_tens = r_tens;
    assign score_ones = r_ones;
    assign lives_left = r_lives;
    assign state      = r_state;
    assign snd_ok     = r_snd_ok;
    assign snd_fail   = r_snd_fail;
    assign game_over  = r_game_over;
endmodule

// File: doc/bopit_engine.md
BOPIT_ENGINE -- requirements
Module: bopit_engine

Interface
REQ-001 Parameter N_SW, default 8: number of switch inputs (1..16).
REQ-002 Parameter N_BTN, default 4: number of button inputs (1..8).
REQ-003 Parameter LIVES, default 3: misses allowed before game over (1..7).
REQ-004 Parameter T_START, default 10: response window in ticks at level 0 (2..99).
REQ-005 Parameter T_MIN, default 3: minimum response window in ticks (1..T_START).
REQ-006 Parameter STEP, default 5: wins per level increase (1..15).
REQ-007 Parameter DELAY, default 3: ticks spent in WIN before the next command.
REQ-008 Ports: clk in 1 system clock; rst in 1 reset; tick in 1 one-cycle time-base enable; start in 1 start/restart request.
REQ-009 Ports: sw in N_SW switch levels; btn in N_BTN button levels, high = pressed; rnd in 8 free-running random value.
REQ-010 Ports: cmd out 5 current command code; cmd_is_btn out 1 high when cmd >= N_SW; time_left out 7 ticks remaining (binary).
REQ-011 Ports: score_tens, score_ones out 4 each, BCD score; lives_left out 3; state out 3 FSM encoding; snd_ok, snd_fail out 1 one-cycle pulses; game_over out 1.
REQ-012 One clock; reset is synchronous and active-high (clk, rst); all state changes on rising clk.

Function
REQ-013 FSM states and encoding: IDLE=0, ARM=1, WAIT=2, WIN=3, OVER=4.
REQ-014 Input actions: switch action = bit of (sw XOR sw_q); button action = rising edge (btn AND NOT btn_q); sw_q and btn_q are registered every cycle in every state.
REQ-015 IDLE: start -> ARM; lives_left=LIVES, score=00, level=0.
REQ-016 ARM, exactly 1 cycle: cmd = rnd mod (N_SW+N_BTN); time_left = max(T_START-level, T_MIN); -> WAIT.
REQ-017 WAIT hit: exactly one action present and it matches cmd (codes 0..N_SW-1 = sw[i], N_SW+j = btn[j]) -> WIN, snd_ok pulse.
REQ-018 WAIT miss: any action present that is not exactly the single commanded one (including the correct action plus any other).
REQ-019 WAIT timeout: tick with time_left==1 and no action in that cycle -> miss; otherwise tick decrements time_left.
REQ-020 Action and tick in the same cycle: action is evaluated and the tick is ignored.
REQ-021 Miss: snd_fail pulse, lives_left decrements; result 0 -> OVER, else -> ARM (new command).
REQ-022 WIN: counts DELAY ticks; on the DELAY-th tick the score increments in BCD (09->10), saturating at 99, then -> ARM.
REQ-023 Level: increments when the win count reaches a multiple of STEP; saturates once T_START-level <= T_MIN.
REQ-024 OVER: game_over=1; cmd, score, time_left frozen; start -> ARM with full restart per REQ-015.
REQ-025 start in ARM/WAIT/WIN restarts per REQ-015 (-> ARM); rst has priority over start.
REQ-026 Actions outside WAIT are discarded (no miss, no hit); edge history still updates.
REQ-027 cmd_is_btn is combinational from cmd; all other outputs are registered.

Reset
REQ-028 rst: state=IDLE, cmd=0, time_left=0, score=00, lives_left=LIVES, level=0, snd_ok=snd_fail=game_over=0.
REQ-029 rst also loads sw_q=sw and btn_q=btn, so no action is generated on the first cycle after reset.
REQ-030 rst asserted mid-game returns to IDLE on the next edge regardless of tick/start/actions.

Verification
REQ-031 rst, start, rnd=3 -> cmd=3, time_left=10; toggle sw[3] -> snd_ok pulse, WIN; 3 ticks -> score 01, ARM.
REQ-032 rnd=9 (cmd=btn[1]), press btn[0] -> snd_fail, lives_left 3->2, new command issued via ARM.
REQ-033 Hold no action for 10 ticks -> miss on the 10th tick; after 3 misses -> OVER, game_over=1, score frozen.
REQ-034 25 consecutive wins with STEP=5 -> time_left at ARM: 10,...,5 per level; with T_MIN=7 it floors at 7; score reads 25 BCD.
REQ-035 Correct action and tick coincide when time_left=1 -> hit, not timeout; correct sw and a btn edge together -> miss.
REQ-036 Score at 99 plus a win -> stays 99; start in OVER -> score 00, lives_left=LIVES, state ARM.
